// File: rtl/boid_frame_writer_pkg.sv
// Shared video geometry and frame-writer FSM encoding.
// Used by the BPU, the VGA controller and the frame writer.
package boid_frame_writer_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int ADDR_WIDTH   = 19;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SEL,
    FETCH,
    PIX
  } state_t;

endpackage

// File: rtl/boid_frame_writer_addr.sv
// Sprite pixel address and on-screen test.
// Offsets dx/dy select one corner of the 2x2 sprite.
module pixel_addr_calc #(
  parameter int AW = 19
) (
  input  logic [AW-1:0] base,
  input  logic [9:0]    x,
  input  logic [8:0]    y,
  input  logic          dx,
  input  logic          dy,
  output logic [AW-1:0] addr,
  output logic          on_screen
);
  import boid_frame_writer_pkg::*;

  logic [10:0] px;
  logic [9:0]  py;

  // widen before the +1 so x=1023 / y=511 cannot wrap on screen
  always_comb begin
    px = {1'b0, x} + {10'd0, dx};
    py = {1'b0, y} + {9'd0, dy};
    on_screen = (px <= 11'(VIDEO_WIDTH - 1))
             && (py <= 10'(VIDEO_HEIGHT - 1));
    addr = base + AW'(dx) + (dy ? AW'(VIDEO_WIDTH) : '0);
  end

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame boid scanner: clears the display buffer, then
// draws a 2x2 sprite for each boid into the display RAM.
module boid_frame_writer #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int ADDR_WIDTH     = boid_frame_writer_pkg::ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      frame_end,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  input  logic [9:0]                boid_x,
  input  logic [8:0]                boid_y,
  output logic                      buf_clear,
  output logic                      pix_we,
  output logic [ADDR_WIDTH-1:0]     pix_addr,
  output logic                      pix_data,
  output logic                      busy,
  output logic [7:0]                overrun_cnt
);
  import boid_frame_writer_pkg::*;

  localparam logic [BITS_FOR_BOIDS-1:0] LAST =
    BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  state_t                    state;
  state_t                    next;
  logic [BITS_FOR_BOIDS-1:0] idx;
  logic [1:0]                k;
  logic [9:0]                x_q;
  logic [8:0]                y_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [ADDR_WIDTH-1:0]     base_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     calc_addr;
  logic                      on;

  pixel_addr_calc #(
    .AW (ADDR_WIDTH)
  ) u_calc (
    .base      (base_q),
    .x         (x_q),
    .y         (y_q),
    .dx        (k[0]),
    .dy        (k[1]),
    .addr      (calc_addr),
    .on_screen (on)
  );

  // y*640 + x as shifts, no multiplier
  always_comb begin
    base_d = (ADDR_WIDTH'(boid_y) << 9)
           + (ADDR_WIDTH'(boid_y) << 7)
           + ADDR_WIDTH'(boid_x);
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  // next-state logic
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (frame_end) next = CLEAR;
      CLEAR:   next = SEL;
      SEL:     next = FETCH;
      FETCH:   next = PIX;
      PIX: begin
        if (k == 2'd3) next = (idx == LAST) ? IDLE : SEL;
      end
      default: next = IDLE;
    endcase
  end

  // Moore outputs; address holds its last value between writes
  always_comb begin
    buf_clear = (state == CLEAR);
    busy      = (state != IDLE);
    pix_we    = (state == PIX) && on;
    pix_addr  = pix_we ? calc_addr : addr_q;
    pix_data  = 1'b1;
    boid_sel  = idx;
  end

  // boid index, sprite sub-counter and captured position
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      k      <= '0;
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= pix_addr;
      unique case (state)
        CLEAR: idx <= '0;
        FETCH: begin
          x_q    <= boid_x;
          y_q    <= boid_y;
          base_q <= base_d;
          k      <= 2'd0;
        end
        PIX: begin
          k <= k + 2'd1;
          if (k == 2'd3 && idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // frames that arrive mid-scan are dropped and counted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= 8'd0;
    end else if (frame_end && state != IDLE
                 && overrun_cnt != 8'hFF) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench for the boid frame writer.
// Writes are logged per cycle and compared to hand-computed lists.
module tb_boid_frame_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_end;
  logic [1:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        buf_clear;
  logic        pix_we;
  logic [18:0] pix_addr;
  logic        pix_data;
  logic        busy;
  logic [7:0]  overrun_cnt;

  logic [9:0] bx [4];
  logic [8:0] by [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int nclr;
  int clr_cyc;
  int last_busy;
  int pulses;
  int guard;
  int unsigned wr_q [$];
  int          wr_cyc [$];
  int unsigned exp_q [$];
  logic [1:0]  sel_log [32];

  always #5 clock = ~clock;

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_frame_writer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_end   (frame_end),
    .boid_sel    (boid_sel),
    .boid_x      (boid_x),
    .boid_y      (boid_y),
    .buf_clear   (buf_clear),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (pix_we) begin
      wr_q.push_back(int'(pix_addr));
      wr_cyc.push_back(cyc);
    end
    if (buf_clear) begin
      nclr++;
      clr_cyc = cyc;
    end
    if (busy) last_busy = cyc;
    if (cyc - t0 >= 0 && cyc - t0 < 32) sel_log[cyc - t0] = boid_sel;
  endtask

  task automatic run_scan(input int e1, input int e2);
    wr_q.delete();
    wr_cyc.delete();
    nclr      = 0;
    clr_cyc   = -1;
    last_busy = -1;
    t0        = cyc;
    frame_end = 1'b1;
    step();
    for (int i = 0; i < 29; i++) begin
      frame_end = ((cyc - t0) == e1) || ((cyc - t0) == e2);
      step();
    end
    frame_end = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_q.size())
        chk($sformatf("%s_addr%0d", tag, i), int'(wr_q[i]), int'(exp_q[i]));
    end
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_nclr"}, nclr, 1);
    chk({tag, "_clr_at"}, clr_cyc - t0, 1);
    chk({tag, "_busy_fall"}, last_busy - t0 + 1, 26);
  endtask

  task automatic set_std_boids();
    bx[0] = 10'd10;  by[0] = 9'd10;
    bx[1] = 10'd100; by[1] = 9'd50;
    bx[2] = 10'd0;   by[2] = 9'd0;
    bx[3] = 10'd300; by[3] = 9'd200;
    exp_q = '{6410, 6411, 7050, 7051,
              32100, 32101, 32740, 32741,
              0, 1, 640, 641,
              128300, 128301, 128940, 128941};
  endtask

  initial begin
    reset_n   = 1'b0;
    frame_end = 1'b0;
    set_std_boids();
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_we", pix_we, 0);
    chk("rst_clear", buf_clear, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_sel", boid_sel, 0);
    chk("rst_data", pix_data, 1);
    reset_n = 1'b1;
    step();
    step();
    chk("idle_busy", busy, 0);

    run_scan(-1, -1);
    check_writes("std");
    check_timing("std");
    if (wr_cyc.size() > 0) chk("std_first_we", wr_cyc[0] - t0, 4);
    chk("std_sel_t2", sel_log[2], 0);
    chk("std_sel_t8", sel_log[8], 1);
    chk("std_sel_t13", sel_log[13], 1);
    chk("std_sel_t14", sel_log[14], 2);
    chk("std_addr_hold", pix_addr, 128941);
    chk("std_ovr", overrun_cnt, 0);

    bx[0] = 10'd639; by[0] = 9'd479;
    bx[1] = 10'd700; by[1] = 9'd20;
    bx[2] = 10'd5;   by[2] = 9'd500;
    bx[3] = 10'd638; by[3] = 9'd0;
    exp_q = '{307199, 638, 639, 1278, 1279};
    run_scan(-1, -1);
    check_writes("edge");
    check_timing("edge");
    if (wr_cyc.size() == 5) begin
      chk("edge_cyc0", wr_cyc[0] - t0, 4);
      chk("edge_cyc1", wr_cyc[1] - t0, 22);
    end

    set_std_boids();
    run_scan(10, 25);
    check_writes("ovr");
    check_timing("ovr");
    chk("ovr_cnt", overrun_cnt, 2);
    chk("ovr_idle", busy, 0);
    run_scan(-1, -1);
    check_writes("after_ovr");
    check_timing("after_ovr");
    chk("after_ovr_cnt", overrun_cnt, 2);

    t0 = cyc;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    while (cyc < t0 + 8) step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", pix_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clear", buf_clear, 0);
    chk("mid_rst_ovr", overrun_cnt, 0);
    step();
    chk("mid_rst_busy2", busy, 0);
    step();
    reset_n = 1'b1;
    wr_q.delete();
    nclr = 0;
    step();
    step();
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_writes", wr_q.size(), 0);
    chk("post_rst_clears", nclr, 0);
    run_scan(-1, -1);
    check_writes("post_rst");
    check_timing("post_rst");

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run_scan(-1, -1);
    check_writes("rel");
    check_timing("rel");

    pulses = 0;
    guard  = 0;
    frame_end = 1'b1;
    step();
    while (pulses < 300 && guard < 5000) begin
      frame_end = 1'b1;
      if (busy) pulses++;
      step();
      guard++;
    end
    frame_end = 1'b0;
    chk("sat_guard", int'(guard < 5000), 1);
    step();
    chk("sat_cnt", overrun_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
